sprite_line_fetcher: RTL and testbench

SPRITE_LINE_FETCHER -- requirements
Module: sprite_line_fetcher

---
 rtl/sprite_line_fetcher.sv | 144 ++++++++++++++
 tb/tb_sprite_line_fetcher.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite fetcher: walks the external sprite list, reads one VRAM line
// per sprite (with optional flips) and presents each line on a valid/ready port.
module sprite_line_fetcher #(
  parameter int MAX_SPRITES = 8,
  parameter int LATENCY     = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         line_start,
  input  logic [4:0]   sprite_count,
  output logic [3:0]   list_idx,
  input  logic [7:0]   list_tile,
  input  logic [3:0]   list_row,
  input  logic         list_hflip,
  input  logic         list_vflip,
  output logic [11:0]  vram_read_addr,
  input  logic [127:0] vram_read_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_slot,
  output logic [127:0] out_pixels,
  output logic         busy,
  output logic         line_done,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam logic [4:0] MAX_N    = 5'(MAX_SPRITES);
  localparam logic [1:0] LAT_LAST = 2'(LATENCY - 1);

  state_e         state_q, state_d;
  logic [4:0]     n_q, n_d;
  logic [3:0]     idx_q, idx_d;
  logic [1:0]     wait_q, wait_d;
  logic           hflip_q, hflip_d;
  logic [11:0]    addr_q, addr_d;
  logic [127:0]   pix_q, pix_d;
  logic [3:0]     slot_q, slot_d;
  logic           done_q, done_d;

  logic [4:0]     n_sat;
  logic [4:0]     idx_inc;
  logic [3:0]     row_eff;
  logic [127:0]   pix_rev;

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      pix_rev[8*k +: 8] = vram_read_data[8*(15-k) +: 8];
    end
  end

  assign n_sat   = (sprite_count > MAX_N) ? MAX_N : sprite_count;
  assign idx_inc = {1'b0, idx_q} + 5'd1;
  assign row_eff = list_vflip ? (4'd15 - list_row) : list_row;

  // Output handshake: a line transfers on any cycle where out_valid && out_ready;
  // out_slot/out_pixels are held unchanged while out_valid is high and out_ready is low.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    hflip_d = hflip_q;
    addr_d  = addr_q;
    pix_d   = pix_q;
    slot_d  = slot_q;
    done_d  = (state_q == S_DONE);

    case (state_q)
      S_IDLE: ;
      S_ISSUE: begin
        addr_d  = {list_tile, row_eff};
        hflip_d = list_hflip;
        wait_d  = 2'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == LAT_LAST) begin
          pix_d   = hflip_q ? pix_rev : vram_read_data;
          slot_d  = idx_q;
          state_d = S_PRESENT;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          idx_d   = idx_inc[3:0];
          state_d = (idx_inc == n_q) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new line always wins, aborting whatever was in flight.
    if (line_start) begin
      n_d     = n_sat;
      idx_d   = 4'd0;
      state_d = (n_sat != 5'd0) ? S_ISSUE : S_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      n_q     <= 5'd0;
      idx_q   <= 4'd0;
      wait_q  <= 2'd0;
      hflip_q <= 1'b0;
      addr_q  <= 12'd0;
      pix_q   <= 128'd0;
      slot_q  <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      hflip_q <= hflip_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      slot_q  <= slot_d;
      done_q  <= done_d;
    end
  end

  assign list_idx       = idx_q;
  assign vram_read_addr = addr_q;
  assign out_valid      = (state_q == S_PRESENT);
  assign out_slot       = slot_q;
  assign out_pixels     = pix_q;
  assign busy           = (state_q != S_IDLE);
  assign line_done      = done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Bench for sprite_line_fetcher: table of whole-line vectors plus hand-written
// sequences for flips, backpressure, aborts, back-to-back lines and reset.
module tb_sprite_line_fetcher;

  localparam int MAXS = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         line_start;
  logic [4:0]   sprite_count;
  logic [3:0]   list_idx;
  logic [7:0]   list_tile;
  logic [3:0]   list_row;
  logic         list_hflip;
  logic         list_vflip;
  logic [11:0]  vram_read_addr;
  logic [127:0] vram_read_data;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_slot;
  logic [127:0] out_pixels;
  logic         busy;
  logic         line_done;
  logic [2:0]   dbg_state;

  always #5 clk = ~clk;

  sprite_line_fetcher #(.MAX_SPRITES(MAXS), .LATENCY(1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .line_start     (line_start),
    .sprite_count   (sprite_count),
    .list_idx       (list_idx),
    .list_tile      (list_tile),
    .list_row       (list_row),
    .list_hflip     (list_hflip),
    .list_vflip     (list_vflip),
    .vram_read_addr (vram_read_addr),
    .vram_read_data (vram_read_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_slot       (out_slot),
    .out_pixels     (out_pixels),
    .busy           (busy),
    .line_done      (line_done),
    .dbg_state      (dbg_state)
  );

  // Sprite list and VRAM environment models
  logic [7:0] tile_t [16];
  logic [3:0] row_t  [16];
  logic       hf_t   [16];
  logic       vf_t   [16];
  logic       data_ident = 1'b0;

  function automatic logic [127:0] vram_line(input logic [11:0] a, input logic ident);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) begin
      r[8*k +: 8] = ident ? 8'(k) : (a[7:0] ^ 8'(k * 29) ^ {a[11:8], 4'h0});
    end
    return r;
  endfunction

  assign list_tile      = tile_t[list_idx];
  assign list_row       = row_t[list_idx];
  assign list_hflip     = hf_t[list_idx];
  assign list_vflip     = vf_t[list_idx];
  assign vram_read_data = vram_line(vram_read_addr, data_ident);

  function automatic logic [11:0] exp_addr(input int i);
    return {tile_t[i], vf_t[i] ? (4'd15 - row_t[i]) : row_t[i]};
  endfunction

  function automatic logic [127:0] exp_pix(input int i);
    logic [127:0] d, r;
    d = vram_line(exp_addr(i), data_ident);
    for (int k = 0; k < 16; k++) r[8*k +: 8] = hf_t[i] ? d[8*(15-k) +: 8] : d[8*k +: 8];
    return r;
  endfunction

  task automatic load_list(input int kind);
    for (int i = 0; i < 16; i++) begin
      tile_t[i] = 8'(i * 37 + 5);
      row_t[i]  = 4'(i * 3);
      hf_t[i]   = i[0];
      vf_t[i]   = i[1];
    end
    if (kind == 0) begin
      tile_t[0] = 8'h12; row_t[0] = 4'd5;
      tile_t[1] = 8'h34; row_t[1] = 4'd0;
      tile_t[2] = 8'hFF; row_t[2] = 4'd15;
      for (int i = 0; i < 3; i++) begin hf_t[i] = 1'b0; vf_t[i] = 1'b0; end
    end
  endtask

  // Scoreboard
  int n_checks = 0;
  int n_err    = 0;
  logic [143:0] exp_q[$];
  logic [11:0]  obs_addr [16];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_line(input int count);
    @(negedge clk);
    line_start   = 1'b1;
    sprite_count = 5'(count);
    @(negedge clk);
    line_start   = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (dbg_state == s) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check(tag, 128'(ok), 128'd1);
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (line_done) begin ok = 1'b1; break; end
    end
    check(tag, 128'(ok), 128'd1);
  endtask

  // Runs one line with out_ready=1; 'started' means the caller already raised line_start.
  task automatic run_line(input int count, input int exp_beats, input int exp_done, input bit started);
    int beats, done_cyc, pulses, nsat;
    logic [11:0]  addr0;
    logic [143:0] item;
    beats = 0; done_cyc = -1; pulses = 0;
    nsat = (count > MAXS) ? MAXS : count;
    exp_q.delete();
    for (int i = 0; i < nsat; i++) exp_q.push_back({exp_addr(i), 4'(i), exp_pix(i)});
    if (!started) begin
      @(negedge clk);
      line_start   = 1'b1;
      sprite_count = 5'(count);
    end
    addr0 = vram_read_addr;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 1) begin
        line_start = 1'b0;
        check("start_busy", 128'(busy), 128'd1);
        check("start_valid", 128'(out_valid), 128'd0);
        check("start_idx", 128'(list_idx), 128'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 128'(exp_q.size()), 128'd1);
        end else begin
          item = exp_q.pop_front();
          check("beat_slot", 128'(out_slot), 128'(item[131:128]));
          check("beat_pixels", out_pixels, item[127:0]);
          check("beat_addr", 128'(vram_read_addr), 128'(item[143:132]));
        end
        if (beats < 16) obs_addr[beats] = vram_read_addr;
        beats++;
      end
      if (line_done) begin
        pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    check("line_beats", 128'(beats), 128'(exp_beats));
    check("line_done_cycle", 128'(done_cyc), 128'(exp_done));
    check("line_done_pulses", 128'(pulses), 128'd1);
    check("idle_after_line", 128'(busy), 128'd0);
    if (exp_beats == 0) check("no_vram_access", 128'(vram_read_addr), 128'(addr0));
  endtask

  typedef struct {
    int count;
    int kind;
    int exp_beats;
    int exp_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [127:0] hold_pix;
    logic [3:0]   hold_slot;
    int           beats, pulses, done_c;
    bit           found;

    vecs[0] = '{3,  0, 3, 11};
    vecs[1] = '{0,  1, 0, 2};
    vecs[2] = '{1,  1, 1, 5};
    vecs[3] = '{8,  1, 8, 26};
    vecs[4] = '{20, 1, 8, 26};
    vecs[5] = '{5,  1, 5, 17};
    vecs[6] = '{31, 1, 8, 26};

    // Clock/reset
    reset_n = 1'b0; line_start = 1'b0; sprite_count = 5'd0; out_ready = 1'b1;
    load_list(1);
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_valid", 128'(out_valid), 128'd0);
    check("rst_done", 128'(line_done), 128'd0);
    check("rst_addr", 128'(vram_read_addr), 128'd0);
    check("rst_pixels", out_pixels, 128'd0);
    check("rst_slot", 128'(out_slot), 128'd0);
    check("rst_state", 128'(dbg_state), 128'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven whole-line vectors
    for (int v = 0; v < 7; v++) begin
      load_list(vecs[v].kind);
      run_line(vecs[v].count, vecs[v].exp_beats, vecs[v].exp_done, 1'b0);
      if (vecs[v].kind == 0) begin
        check("basic_addr0", 128'(obs_addr[0]), 128'h125);
        check("basic_addr1", 128'(obs_addr[1]), 128'h340);
        check("basic_addr2", 128'(obs_addr[2]), 128'hFFF);
      end
    end

    // Flips
    load_list(1);
    data_ident = 1'b1;
    tile_t[0] = 8'h01; row_t[0] = 4'd2; vf_t[0] = 1'b1; hf_t[0] = 1'b1;
    start_line(1);
    wait_state(3'd3, "flip_reach_present");
    check("flip_addr", 128'(vram_read_addr), 128'h01D);
    check("flip_pixels", out_pixels, 128'h000102030405060708090A0B0C0D0E0F);
    wait_done("flip_done");
    data_ident = 1'b0;
    @(negedge clk);

    // Backpressure
    load_list(1);
    out_ready = 1'b0;
    start_line(2);
    wait_state(3'd3, "bp_reach_present");
    hold_pix  = out_pixels;
    hold_slot = out_slot;
    check("bp_first_pixels", out_pixels, exp_pix(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", 128'(out_valid), 128'd1);
      check("bp_pixels_held", out_pixels, hold_pix);
      check("bp_slot_held", 128'(out_slot), 128'(hold_slot));
      check("bp_no_issue", 128'(dbg_state), 128'd3);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_issue_after_hs", 128'(dbg_state), 128'd1);
    check("bp_idx_after_hs", 128'(list_idx), 128'd1);
    wait_done("bp_done");
    @(negedge clk);

    // Abort during slot 2 of an 8-sprite line
    load_list(1);
    start_line(8);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid && out_slot == 4'd2) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("abort_reach_slot2", 128'(found), 128'd1);
    line_start   = 1'b1;
    sprite_count = 5'd4;
    run_line(4, 4, 14, 1'b1);

    // line_start in the DONE cycle
    load_list(1);
    start_line(1);
    wait_state(3'd4, "dd_reach_done");
    line_start   = 1'b1;
    sprite_count = 5'd2;
    @(negedge clk);
    line_start = 1'b0;
    check("dd_old_done_pulse", 128'(line_done), 128'd1);
    check("dd_new_issue", 128'(dbg_state), 128'd1);
    beats = 0; pulses = 0; done_c = -1;
    for (int c = 2; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        check("dd_slot", 128'(out_slot), 128'(beats));
        beats++;
      end
      if (line_done) begin pulses++; if (done_c < 0) done_c = c; end
      if (done_c >= 0 && c >= done_c + 2) break;
    end
    check("dd_beats", 128'(beats), 128'd2);
    check("dd_done_cycle", 128'(done_c), 128'd8);
    check("dd_done_pulses", 128'(pulses), 128'd1);

    // Asynchronous reset mid-WAIT
    load_list(1);
    start_line(3);
    wait_state(3'd2, "rst_reach_wait");
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 128'(out_valid), 128'd0);
    check("arst_busy", 128'(busy), 128'd0);
    check("arst_done", 128'(line_done), 128'd0);
    check("arst_addr", 128'(vram_read_addr), 128'd0);
    check("arst_pixels", out_pixels, 128'd0);
    check("arst_slot", 128'(out_slot), 128'd0);
    check("arst_idx", 128'(list_idx), 128'd0);
    check("arst_state", 128'(dbg_state), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_idle", 128'(busy), 128'd0);
      check("post_rst_addr", 128'(vram_read_addr), 128'd0);
    end
    run_line(2, 2, 8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
